// File: rtl/switching_pkg.sv
//------------------------------------------------------------------------------
// switching_pkg
//   Shared types and constants for the PMOD complementary PWM sequencer.
//   - state_t : sequencer states
//   - cfg_t   : one configuration word {half, dead, bursts}
//   - helpers : on-phase length and configuration legality
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package switching_pkg;

  // Field widths of the configuration word. The top-level width parameters
  // must match these, since active and shadow registers are held as cfg_t.
  localparam int CFG_CNT_W   = 16;
  localparam int CFG_DEAD_W  = 8;
  localparam int CFG_BURST_W = 16;

  // Reset configuration: 2.083 kHz at 100 MHz with 50-cycle dead time.
  localparam int DEF_HALF = 24000;
  localparam int DEF_DEAD = 50;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_ON    = 3'd1,
    DEAD_AB = 3'd2,
    B_ON    = 3'd3,
    DEAD_BA = 3'd4
  } state_t;

  typedef struct packed {
    logic [CFG_CNT_W-1:0]   half;
    logic [CFG_DEAD_W-1:0]  dead;
    logic [CFG_BURST_W-1:0] bursts;
  } cfg_t;

  // Timer load value for an on-phase: the phase lasts H-D cycles and the
  // timer counts down to zero inclusive.
  function automatic logic [CFG_CNT_W-1:0] on_load(input cfg_t c);
    return c.half - CFG_CNT_W'(c.dead) - CFG_CNT_W'(1);
  endfunction

  // Timer load value for a dead-time phase of D cycles (only used when D>0).
  function automatic logic [CFG_CNT_W-1:0] dead_load(input cfg_t c);
    return CFG_CNT_W'(c.dead - CFG_DEAD_W'(1));
  endfunction

  // A configuration is usable when H>=2 and D<H, which keeps every phase
  // at least one cycle long.
  function automatic logic cfg_legal(input cfg_t c);
    return (c.half >= CFG_CNT_W'(2)) && (CFG_CNT_W'(c.dead) < c.half);
  endfunction

endpackage

`default_nettype wire

// File: rtl/switching_sequencer_phase_timer.sv
//------------------------------------------------------------------------------
// phase_timer
//   Loadable down-counter that measures the length of one sequencer phase.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load       : load strobe, takes priority over counting
//     load_val   : value loaded (phase length minus one)
//     zero       : counter has reached zero (last cycle of the phase)
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module phase_timer
  import switching_pkg::*;
#(
  parameter int W = CFG_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Saturates at zero so an idle sequencer leaves the counter parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/switching_sequencer.sv
//------------------------------------------------------------------------------
// switching_sequencer
//   Complementary PWM pair generator with programmable half-period and dead
//   time, continuous or counted-burst operation, and glitch-free
//   reconfiguration at period boundaries.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     cfg_valid / cfg_ready : configuration handshake
//     cfg_half/dead/bursts  : H, D and N (N=0 runs continuously)
//     cfg_err               : one-cycle pulse, offered config rejected
//     start, stop           : level-sampled run control
//     pwm_a, pwm_b          : high-side / low-side drive (registered)
//     busy                  : sequencer not idle
//     done                  : one-cycle pulse when a run ends
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module switching_sequencer
  import switching_pkg::*;
#(
  parameter int CNT_W    = CFG_CNT_W,
  parameter int DEAD_W   = CFG_DEAD_W,
  parameter int BURST_W  = CFG_BURST_W,
  parameter int DEF_HALF = switching_pkg::DEF_HALF,
  parameter int DEF_DEAD = switching_pkg::DEF_DEAD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [DEAD_W-1:0]  cfg_dead,
  input  logic [BURST_W-1:0] cfg_bursts,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  output logic               pwm_a,
  output logic               pwm_b,
  output logic               busy,
  output logic               done
);

  state_t state, state_nxt;

  cfg_t active;     // configuration governing the current period
  cfg_t shadow;     // configuration waiting for the next boundary
  cfg_t eff;        // configuration the next period will use
  cfg_t cfg_in;
  logic pending;

  logic                   stop_req;
  logic                   counted;    // run was started with N != 0
  logic [CFG_BURST_W-1:0] burst_cnt;

  logic                 t_load;
  logic [CFG_CNT_W-1:0] t_val;
  logic                 t_zero;

  logic boundary;
  logic run_end;
  logic start_go;
  logic cfg_fire;

  assign cfg_in   = '{half: cfg_half, dead: cfg_dead, bursts: cfg_bursts};
  assign eff      = pending ? shadow : active;
  assign cfg_fire = cfg_valid & ~pending;
  assign start_go = (state == IDLE) & start & ~stop;

  // A stop seen in the boundary cycle itself ends the run there as well.
  assign run_end  = stop_req | stop | (counted & (burst_cnt == CFG_BURST_W'(1)));

  assign cfg_ready = ~pending;

  phase_timer #(
    .W (CFG_CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  // Next-state and timer-load decode. Within a period the phase lengths come
  // from the active config; a new period takes its lengths from eff so a
  // pending shadow applies from the very first cycle after the boundary.
  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_val     = '0;
    boundary  = 1'b0;
    case (state)
      IDLE: begin
        if (start_go) begin
          state_nxt = A_ON;
          t_load    = 1'b1;
          t_val     = on_load(eff);
        end
      end
      A_ON: begin
        if (t_zero) begin
          t_load = 1'b1;
          if (active.dead != '0) begin
            state_nxt = DEAD_AB;
            t_val     = dead_load(active);
          end else begin
            state_nxt = B_ON;
            t_val     = on_load(active);
          end
        end
      end
      DEAD_AB: begin
        if (t_zero) begin
          state_nxt = B_ON;
          t_load    = 1'b1;
          t_val     = on_load(active);
        end
      end
      B_ON: begin
        if (t_zero) begin
          if (active.dead != '0) begin
            state_nxt = DEAD_BA;
            t_load    = 1'b1;
            t_val     = dead_load(active);
          end else begin
            boundary = 1'b1;
          end
        end
      end
      DEAD_BA: begin
        if (t_zero) begin
          boundary = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (boundary) begin
      if (run_end) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = A_ON;
        t_load    = 1'b1;
        t_val     = on_load(eff);
      end
    end
  end

  // State and registered outputs decoded from the next state, so the pins
  // change on the same edge as the state and never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pwm_a   <= 1'b0;
      pwm_b   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      pwm_a   <= (state_nxt == A_ON);
      pwm_b   <= (state_nxt == B_ON);
      busy    <= (state_nxt != IDLE);
      done    <= boundary & run_end;
      cfg_err <= cfg_fire & ~cfg_legal(cfg_in);
    end
  end

  // Stop request and burst counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_req  <= 1'b0;
      counted   <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (state_nxt == IDLE) begin
        stop_req <= 1'b0;
      end else if ((state != IDLE) && stop) begin
        stop_req <= 1'b1;
      end

      if (start_go) begin
        burst_cnt <= eff.bursts;
        counted   <= (eff.bursts != '0);
      end else if (boundary && counted) begin
        burst_cnt <= burst_cnt - CFG_BURST_W'(1);
      end
    end
  end

  // Configuration storage. A config left pending when the run ended (offered
  // in the final cycle) is applied as soon as the sequencer is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '{half:   CFG_CNT_W'(DEF_HALF),
                   dead:   CFG_DEAD_W'(DEF_DEAD),
                   bursts: '0};
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (pending && (boundary || (state == IDLE))) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (cfg_fire && cfg_legal(cfg_in)) begin
        if (state == IDLE) begin
          active <= cfg_in;
        end else begin
          shadow  <= cfg_in;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_switching_sequencer.sv
//------------------------------------------------------------------------------
// tb_switching_sequencer
//   Directed bench for switching_sequencer. Expected per-cycle output
//   patterns {pwm_a, pwm_b, busy, done} are queued as each run is launched
//   and compared cycle by cycle as the DUT produces them.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_switching_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_half;
  logic [7:0]  cfg_dead;
  logic [15:0] cfg_bursts;
  logic        cfg_err;
  logic        start;
  logic        stop;
  logic        pwm_a;
  logic        pwm_b;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int seq_idx = 0;

  typedef struct packed {
    logic a;
    logic b;
    logic bz;
    logic dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  switching_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_half   (cfg_half),
    .cfg_dead   (cfg_dead),
    .cfg_bursts (cfg_bursts),
    .cfg_err    (cfg_err),
    .start      (start),
    .stop       (stop),
    .pwm_a      (pwm_a),
    .pwm_b      (pwm_b),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: one expected entry per cycle while a run is queued,
  // plus a non-overlap check on every cycle.
  always @(posedge clk) begin
    #1;
    checks++;
    assert ((pwm_a & pwm_b) === 1'b0) else begin
      errors++;
      $error("FAIL overlap observed a=%0b b=%0b required not both high", pwm_a, pwm_b);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      seq_idx++;
      checks++;
      assert ({pwm_a, pwm_b, busy, done} === e) else begin
        errors++;
        $error("FAIL seq[%0d] observed {a,b,busy,done}=%b required=%b",
               seq_idx, {pwm_a, pwm_b, busy, done}, e);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_seg(input logic a, input logic b, input logic bz, input logic dn, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({a, b, bz, dn});
  endtask

  task automatic push_period(input int h, input int d);
    if (d > 0) begin
      push_seg(1'b1, 1'b0, 1'b1, 1'b0, h - d);
      push_seg(1'b0, 1'b0, 1'b1, 1'b0, d);
      push_seg(1'b0, 1'b1, 1'b1, 1'b0, h - d);
      push_seg(1'b0, 1'b0, 1'b1, 1'b0, d);
    end else begin
      push_seg(1'b1, 1'b0, 1'b1, 1'b0, h);
      push_seg(1'b0, 1'b1, 1'b1, 1'b0, h);
    end
  endtask

  // First idle cycle carries the done pulse, the next one does not.
  task automatic push_end();
    push_seg(1'b0, 1'b0, 1'b0, 1'b1, 1);
    push_seg(1'b0, 1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Offer a config at this negedge; returns one cycle later with valid low.
  task automatic offer(input int h, input int d, input int n);
    cfg_valid  = 1'b1;
    cfg_half   = 16'(h);
    cfg_dead   = 8'(d);
    cfg_bursts = 16'(n);
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_half   = '0;
    cfg_dead   = '0;
    cfg_bursts = '0;
    start      = 1'b0;
    stop       = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_pwm_a", pwm_a, 0);
    check("rst_pwm_b", pwm_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Burst of 3 periods, H=10 D=2: done 60 cycles after first pwm_a rise
    offer(10, 2, 3);
    check("t1_cfg_err", cfg_err, 0);
    check("t1_cfg_ready", cfg_ready, 1);
    repeat (3) push_period(10, 2);
    push_end();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("t1", 200);
    check("t1_busy_after", busy, 0);

    // Continuous H=10 D=0, reconfigure to H=6 D=1 in cycle 5 of A_ON
    offer(10, 0, 0);
    push_period(10, 0);
    push_period(6, 1);
    push_end();
    start = 1'b1;
    @(negedge clk);                    // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);         // cycle 5
    check("t2_ready_before", cfg_ready, 1);
    offer(6, 1, 0);                    // cycle 6
    check("t2_ready_low", cfg_ready, 0);
    repeat (14) @(negedge clk);        // cycle 20, last of period 1
    check("t2_ready_low_end", cfg_ready, 0);
    @(negedge clk);                    // cycle 21
    check("t2_ready_back", cfg_ready, 1);
    @(negedge clk);                    // cycle 22
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain("t2", 100);

    // Illegal configs are rejected and leave the H=6 D=1 config in place
    offer(10, 10, 0);
    check("t3_err_d_eq_h", cfg_err, 1);
    @(negedge clk);
    check("t3_err_clear1", cfg_err, 0);
    offer(1, 0, 0);
    check("t3_err_h1", cfg_err, 1);
    @(negedge clk);
    check("t3_err_clear2", cfg_err, 0);
    check("t3_ready", cfg_ready, 1);

    // start together with stop in IDLE: nothing happens
    push_seg(1'b0, 1'b0, 1'b0, 1'b0, 3);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    drain("t3_startstop", 10);

    // One period with unchanged H=6 D=1 timing, stop from cycle 1
    push_period(6, 1);
    push_end();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    drain("t3_run", 50);

    // Continuous H=10 D=2, stop during B_ON completes the period
    offer(10, 2, 0);
    push_period(10, 2);
    push_end();
    start = 1'b1;
    @(negedge clk);                    // cycle 1
    start = 1'b0;
    repeat (11) @(negedge clk);        // cycle 12, B_ON
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain("t4", 50);

    // Continuous H=10 D=2, change to D=0 mid-period lands on the boundary
    push_period(10, 2);
    push_period(10, 0);
    push_end();
    start = 1'b1;
    @(negedge clk);                    // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);         // cycle 5
    offer(10, 0, 0);                   // cycle 6
    repeat (19) @(negedge clk);        // cycle 25
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain("t6", 80);

    // Asynchronous reset in the middle of A_ON, then default timing
    push_seg(1'b1, 1'b0, 1'b1, 1'b0, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("t5_pre", 10);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_pwm_a", pwm_a, 0);
    check("t5_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_ready_after_rst", cfg_ready, 1);
    @(negedge clk);
    push_period(24000, 50);
    push_end();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain("t5_default", 48200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/switching_sequencer.md
Name: switching_sequencer

Overview:
- Controller for the PMOD switching outputs on JC/JD. Sequences a complementary PWM pair (pwm_a, pwm_b) with programmable half-period and dead time.
- Runs in continuous mode or for a counted burst of periods.
- New configuration arrives through a valid/ready port into shadow registers. It takes effect only at a period boundary, so no runt pulses are produced.
- Sits between the board-control logic and the PMOD pins. Replaces the fixed free-running divider with a startable, stoppable, reconfigurable source.

Parameters:
- CNT_W, 16, width of half-period and phase counters.
- DEAD_W, 8, width of dead-time field.
- BURST_W, 16, width of burst-count field.
- DEF_HALF, 24000, reset half-period in clk cycles (2.083 kHz at 100 MHz).
- DEF_DEAD, 50, reset dead time in clk cycles.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  shadow slot free
- cfg_half  in  CNT_W  half-period H, in cycles
- cfg_dead  in  DEAD_W  dead time D, in cycles
- cfg_bursts  in  BURST_W  periods per run N; 0 = continuous
- cfg_err  out  1  one-cycle pulse: offered config rejected
- start  in  1  level-sampled start request
- stop  in  1  level-sampled graceful stop request
- pwm_a  out  1  high-side drive
- pwm_b  out  1  low-side drive
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse when run ends

Behaviour:
- Reset (async assert, sync release):
  - State IDLE. pwm_a=0, pwm_b=0, busy=0, done=0, cfg_err=0, cfg_ready=1.
  - Active config = {DEF_HALF, DEF_DEAD, 0}. Shadow pending=0.
- States: IDLE, A_ON, DEAD_AB, B_ON, DEAD_BA. One period = A_ON (H-D) + DEAD_AB (D) + B_ON (H-D) + DEAD_BA (D) = 2H cycles.
- When D=0, DEAD states are skipped; A_ON and B_ON each last H.
- Outputs are registered and decoded from the next state:
  - pwm_a=1 only in A_ON.
  - pwm_b=1 only in B_ON.
  - pwm_a and pwm_b are never both 1.
- Start:
  - start=1 sampled in IDLE at edge t → A_ON from edge t+1, so pwm_a=1 and busy=1 in cycle t+1.
  - start is ignored outside IDLE.
- Config accept:
  - Transfer occurs when cfg_valid & cfg_ready.
  - Valid iff H≥2 and D<H. Invalid → cfg_err pulse next cycle; nothing stored.
  - Valid in IDLE → active config loaded next cycle; cfg_ready stays 1.
  - Valid while busy → stored in shadow, pending=1, cfg_ready=0.
- Period boundary (last cycle of DEAD_BA, or of B_ON when D=0):
  - If pending: active←shadow, pending=0, cfg_ready=1 the following cycle.
  - The burst counter reloads from the new N only when a new run starts. A mid-run N change applies to the next run.
- Burst:
  - Counter loads N at start and decrements at each period boundary.
  - At the boundary where it reaches 0: go to IDLE, done=1 for one cycle, busy=0.
  - N=0 never terminates.
- Stop:
  - stop=1 in any run state latches stop_req.
  - The current period completes; at the boundary go to IDLE and pulse done.
  - stop in IDLE is a no-op.
  - start and stop together in IDLE: stop wins and start is ignored.
- Simultaneous events at the same boundary:
  - Burst end and stop_req produce a single done pulse.
  - A pending config is still applied.
- Reset mid-run: outputs go low immediately (async), and all state, including pending shadow, is discarded.
- Counter width: phase counter is CNT_W bits, loaded with H-D-1 or D-1, counting down to 0. No wrap is possible because H<2^CNT_W.

Decomposition:
- Package switching_pkg holds:
  - state enum (IDLE, A_ON, DEAD_AB, B_ON, DEAD_BA);
  - DEF_HALF, DEF_DEAD;
  - cfg struct {half, dead, bursts}.
- One sub-module, phase_timer: loadable down-counter with load value, load strobe and a zero flag. It is instantiated once for the phase counter.
- Burst counter and FSM stay in the top module.

Test Plan:
- Reset, cfg H=10 D=2 N=3, start → pwm_a high 8 cycles, both low 2, pwm_b high 8, both low 2, repeated 3 times. done pulses exactly 60 cycles after the first pwm_a rise; busy=0 thereafter.
- Run H=10 D=0 N=0; offer H=6 D=1 at cycle 5 of A_ON → cfg_ready=0 until boundary. The first period is unchanged at 20 cycles; the next is 12 cycles: A 5, dead 1, B 5, dead 1.
- Offer H=10 D=10, and separately H=1 D=0 → cfg_err pulse for each; active config unchanged and output timing unchanged.
- Continuous run H=10 D=2; assert stop during B_ON → period completes, IDLE at boundary, single done pulse, no truncated pulse.
- Assert rst_n=0 mid A_ON → pwm_a=0 within the same cycle (async). After release, a start uses DEF_HALF/DEF_DEAD timing: A high 23950 cycles.
- Continuous run with pwm_a and pwm_b checked every cycle across a config change that sets D from 2 to 0 → never both high, and the change lands on a boundary.
